// File: rtl/layer_sequencer.sv
// layer_sequencer: sequences CNN layers through load/start/run, arbitrates weight/bias reads, flags interrupt and sequencing errors
module layer_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int ADDR_W = 16,
  parameter int IDX_W = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pixel_store_done,
  input  logic [NUM_LAYERS-1:0]        weight_store_done,
  input  logic [NUM_LAYERS-1:0]        bias_store_done,
  input  logic [IDX_W-1:0]             last_layer,
  input  logic [NUM_LAYERS-1:0]        layer_calculation_done,
  input  logic [NUM_LAYERS-1:0]        layer_read_weight_signal,
  input  logic [NUM_LAYERS-1:0]        layer_read_bias_signal,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_read_weight_addr,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_read_bias_addr,
  input  logic                         interrupt_clear,
  output logic [NUM_LAYERS-1:0]        layer_start,
  output logic [IDX_W-1:0]             active_layer,
  output logic                         read_weight_signal_data,
  output logic                         read_bias_signal_data,
  output logic [ADDR_W-1:0]            read_weight_addr_data,
  output logic [ADDR_W-1:0]            read_bias_addr_data,
  output logic                         busy,
  output logic                         interrupt_signal,
  output logic                         seq_error
);
  typedef enum logic [2:0] {IDLE, WAIT_LOAD, START, RUN, DONE} state_t;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_LAYERS - 1);
  state_t state_q, state_d;
  logic [IDX_W-1:0] active_q, active_d, last_q, last_d;
  logic [NUM_LAYERS-1:0] start_q, start_d, act_oh;
  logic busy_q, busy_d, irq_q, irq_d, err_q, err_d;
  logic loaded, cur_done, irq_set, err_set, run;
  assign act_oh = NUM_LAYERS'(1) << active_q;
  assign run = state_q == RUN;
  assign loaded = |(weight_store_done & bias_store_done & act_oh);
  assign cur_done = |(layer_calculation_done & act_oh);
  assign irq_set = run && cur_done && active_q >= last_q;
  assign err_set = run ? |(layer_calculation_done & ~act_oh) : |layer_calculation_done;
  always_comb begin
    state_d = state_q;
    active_d = active_q;
    last_d = last_q;
    case (state_q)
      IDLE: if (pixel_store_done) begin
        state_d = WAIT_LOAD;
        active_d = '0;
        last_d = (last_layer > MAX_IDX) ? MAX_IDX : last_layer;
      end
      WAIT_LOAD: state_d = loaded ? START : WAIT_LOAD;
      START: state_d = RUN;
      RUN: if (cur_done) begin
        state_d = irq_set ? DONE : WAIT_LOAD;
        active_d = irq_set ? active_q : active_q + IDX_W'(1);
      end
      DONE: state_d = interrupt_clear ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    start_d = (state_q == WAIT_LOAD && loaded) ? act_oh : '0;
    busy_d = state_d inside {WAIT_LOAD, START, RUN};
    irq_d = irq_set | (irq_q & ~interrupt_clear);
    err_d = err_set | (err_q & ~(interrupt_clear & (state_q == IDLE || state_q == DONE)));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      active_q <= '0;
      last_q <= '0;
      start_q <= '0;
      busy_q <= 1'b0;
      irq_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      active_q <= active_d;
      last_q <= last_d;
      start_q <= start_d;
      busy_q <= busy_d;
      irq_q <= irq_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    read_weight_signal_data = run && |(layer_read_weight_signal & act_oh);
    read_bias_signal_data = run && |(layer_read_bias_signal & act_oh);
    read_weight_addr_data = '0;
    read_bias_addr_data = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (run && active_q == IDX_W'(i)) begin
        read_weight_addr_data = layer_read_weight_addr[i*ADDR_W +: ADDR_W];
        read_bias_addr_data = layer_read_bias_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end
  assign layer_start = start_q;
  assign active_layer = active_q;
  assign busy = busy_q;
  assign interrupt_signal = irq_q;
  assign seq_error = err_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scoreboard bench for layer_sequencer
module tb_layer_sequencer;
  localparam int NL = 4;
  localparam int AW = 16;
  localparam int IW = 3;
  logic clk = 1'b0, rst = 1'b1, pixel = 1'b0, int_clr = 1'b0;
  logic [NL-1:0] wdone = '0, bdone = '0, cdone = '0, rw_sig = '0, rb_sig = '0;
  logic [IW-1:0] last = '0;
  logic [NL*AW-1:0] rw_addr = '0, rb_addr = '0;
  logic [NL-1:0] layer_start;
  logic [IW-1:0] active_layer;
  logic rw_out, rb_out, busy, irq, err;
  logic [AW-1:0] rw_addr_out, rb_addr_out;
  int checks = 0, errors = 0, cyc = 0;
  logic irq_prev = 1'b0;
  typedef struct {int code; int at;} ev_t;
  ev_t q[$];

  layer_sequencer #(.NUM_LAYERS(NL), .ADDR_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .pixel_store_done(pixel),
    .weight_store_done(wdone), .bias_store_done(bdone), .last_layer(last),
    .layer_calculation_done(cdone),
    .layer_read_weight_signal(rw_sig), .layer_read_bias_signal(rb_sig),
    .layer_read_weight_addr(rw_addr), .layer_read_bias_addr(rb_addr),
    .interrupt_clear(int_clr), .layer_start(layer_start), .active_layer(active_layer),
    .read_weight_signal_data(rw_out), .read_bias_signal_data(rb_out),
    .read_weight_addr_data(rw_addr_out), .read_bias_addr_data(rb_addr_out),
    .busy(busy), .interrupt_signal(irq), .seq_error(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int code, input int at);
    ev_t e;
    e.code = code;
    e.at = at;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // codes: one-hot layer_start value for a start pulse, 16 for interrupt rising
  task automatic check_ev(input int code);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL event unexpected actual code=%0d cycle=%0d required none", code, cyc);
    end else begin
      e = q.pop_front();
      if (e.code != code || e.at != cyc) begin
        errors++;
        $display("FAIL event actual code=%0d cycle=%0d required code=%0d cycle=%0d", code, cyc, e.code, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (layer_start != '0) check_ev(int'(layer_start));
      if (irq && !irq_prev) check_ev(16);
    end
    irq_prev = irq;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk("rst_start", 32'(layer_start), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_active", 32'(active_layer), 0);
    chk("rst_rw", 32'(rw_out), 0);
    rst = 1'b0;
    step(1);
    // two-layer run, last_layer=1
    wdone = '1;
    bdone = '1;
    last = 3'd1;
    rw_sig = 4'b0011;
    rb_sig = 4'b0001;
    rw_addr[0 +: AW] = 16'h0010;
    rw_addr[AW +: AW] = 16'h0ABC;
    rb_addr[0 +: AW] = 16'h0123;
    rb_addr[AW +: AW] = 16'h0DEF;
    pixel = 1'b1;
    push_ev(1, cyc + 2);
    step(1);
    pixel = 1'b0;
    step(2);
    chk("a_busy_run", 32'(busy), 1);
    chk("a_rw_addr_l0", 32'(rw_addr_out), 32'h0010);
    cdone = 4'b0001;
    push_ev(2, cyc + 2);
    step(1);
    cdone = '0;
    chk("a_wait_busy", 32'(busy), 1);
    chk("a_wait_rw_sig", 32'(rw_out), 0);
    chk("a_wait_rw_addr", 32'(rw_addr_out), 0);
    step(2);
    chk("a_active", 32'(active_layer), 1);
    chk("a_rw_sig", 32'(rw_out), 1);
    chk("a_rw_addr", 32'(rw_addr_out), 32'h0ABC);
    chk("a_rb_sig_ignored", 32'(rb_out), 0);
    chk("a_rb_addr", 32'(rb_addr_out), 32'h0DEF);
    cdone = 4'b0010;
    push_ev(16, cyc + 1);
    step(1);
    cdone = '0;
    chk("a_irq", 32'(irq), 1);
    chk("a_done_busy", 32'(busy), 0);
    chk("a_err", 32'(err), 0);
    int_clr = 1'b1;
    step(1);
    int_clr = 1'b0;
    chk("a_irq_clr", 32'(irq), 0);
    // stalled load of layer 1 weights
    wdone = 4'b1101;
    pixel = 1'b1;
    push_ev(1, cyc + 2);
    step(1);
    pixel = 1'b0;
    step(2);
    cdone = 4'b0001;
    step(1);
    cdone = '0;
    step(3);
    chk("b_stall_busy", 32'(busy), 1);
    chk("b_stall_active", 32'(active_layer), 1);
    chk("b_stall_start", 32'(layer_start), 0);
    wdone = '1;
    push_ev(2, cyc + 1);
    step(2);
    // final done together with interrupt_clear: set wins
    cdone = 4'b0010;
    int_clr = 1'b1;
    push_ev(16, cyc + 1);
    step(1);
    cdone = '0;
    int_clr = 1'b0;
    chk("b_irq_set_wins", 32'(irq), 1);
    // pixel held high in DONE must not restart; last_layer=7 clamps to 3
    pixel = 1'b1;
    last = 3'd7;
    step(3);
    chk("c_done_hold_busy", 32'(busy), 0);
    chk("c_done_hold_irq", 32'(irq), 1);
    int_clr = 1'b1;
    push_ev(1, cyc + 3);
    step(1);
    int_clr = 1'b0;
    chk("c_idle_irq", 32'(irq), 0);
    chk("c_idle_busy", 32'(busy), 0);
    step(1);
    pixel = 1'b0;
    chk("c_wait_busy", 32'(busy), 1);
    step(2);
    cdone = 4'b0010;
    step(1);
    cdone = '0;
    chk("c_err_set", 32'(err), 1);
    chk("c_err_active", 32'(active_layer), 0);
    chk("c_err_busy", 32'(busy), 1);
    for (int i = 0; i < NL; i++) begin
      cdone = NL'(1) << i;
      if (i < NL - 1) push_ev(1 << (i + 1), cyc + 2);
      else push_ev(16, cyc + 1);
      step(1);
      cdone = '0;
      if (i < NL - 1) step(2);
    end
    chk("c_irq", 32'(irq), 1);
    chk("c_active_last", 32'(active_layer), 3);
    chk("c_err_sticky", 32'(err), 1);
    int_clr = 1'b1;
    step(1);
    int_clr = 1'b0;
    chk("c_err_clr", 32'(err), 0);
    chk("c_irq_clr", 32'(irq), 0);
    // done outside RUN
    cdone = 4'b0001;
    step(1);
    cdone = '0;
    chk("d_idle_err", 32'(err), 1);
    chk("d_idle_busy", 32'(busy), 0);
    int_clr = 1'b1;
    step(1);
    int_clr = 1'b0;
    chk("d_idle_err_clr", 32'(err), 0);
    // reset mid-RUN
    last = 3'd1;
    pixel = 1'b1;
    push_ev(1, cyc + 2);
    step(1);
    pixel = 1'b0;
    step(2);
    chk("e_run_rw_sig", 32'(rw_out), 1);
    chk("e_run_rw_addr", 32'(rw_addr_out), 32'h0010);
    #1;
    rst = 1'b1;
    #1;
    chk("e_rst_busy", 32'(busy), 0);
    chk("e_rst_rw_sig", 32'(rw_out), 0);
    chk("e_rst_rw_addr", 32'(rw_addr_out), 0);
    chk("e_rst_rb_addr", 32'(rb_addr_out), 0);
    chk("e_rst_active", 32'(active_layer), 0);
    step(1);
    rst = 1'b0;
    cdone = 4'b0001;
    step(1);
    cdone = 4'b0010;
    step(1);
    cdone = '0;
    step(4);
    chk("e_after_busy", 32'(busy), 0);
    chk("e_after_irq", 32'(irq), 0);
    chk("pending_events", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2, number of CNN layers sequenced (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 16, width of weight and bias read addresses.
REQ-003 SHALL have parameter IDX_W, default 3, width of layer index fields.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port pixel_store_done  input  1  level; input image fully loaded.
REQ-007 SHALL have port weight_store_done  input  NUM_LAYERS  level; bit i means layer i weights are loaded.
REQ-008 SHALL have port bias_store_done  input  NUM_LAYERS  level; bit i means layer i biases are loaded.
REQ-009 SHALL have port last_layer  input  IDX_W  index of the final layer to run; sampled at start.
REQ-010 SHALL have port layer_calculation_done  input  NUM_LAYERS  bit i pulses when layer i finishes.
REQ-011 SHALL have ports layer_read_weight_signal and layer_read_bias_signal  input  NUM_LAYERS  per-layer read requests.
REQ-012 SHALL have ports layer_read_weight_addr and layer_read_bias_addr  input  NUM_LAYERS*ADDR_W  per-layer addresses; layer i uses slice [i*ADDR_W +: ADDR_W].
REQ-013 SHALL have port interrupt_clear  input  1  pulse; clears the interrupt.
REQ-014 SHALL have port layer_start  output  NUM_LAYERS  one-cycle start pulse per layer.
REQ-015 SHALL have port active_layer  output  IDX_W  index of the layer that owns the memories.
REQ-016 SHALL have ports read_weight_signal_data and read_bias_signal_data  output  1  arbitrated read strobes.
REQ-017 SHALL have ports read_weight_addr_data and read_bias_addr_data  output  ADDR_W  arbitrated read addresses.
REQ-018 SHALL have ports busy, interrupt_signal and seq_error  output  1  status flags.

Function
REQ-019 SHALL use the states IDLE, WAIT_LOAD, START, RUN and DONE.
REQ-020 IDLE->WAIT_LOAD SHALL happen when pixel_store_done=1; last_layer SHALL be latched (clamped to NUM_LAYERS-1) and active_layer set to 0.
REQ-021 WAIT_LOAD->START SHALL happen on the first cycle where weight_store_done[active_layer] and bias_store_done[active_layer] are both 1.
REQ-022 START SHALL last exactly one cycle, assert layer_start[active_layer] in that cycle only, and then go to RUN.
REQ-023 In RUN, when layer_calculation_done[active_layer]=1 and active_layer<latched last_layer, SHALL increment active_layer and go to WAIT_LOAD.
REQ-024 In RUN, when layer_calculation_done[active_layer]=1 and active_layer equals latched last_layer, SHALL go to DONE and set interrupt_signal=1 on the next cycle.
REQ-025 DONE->IDLE SHALL happen on interrupt_clear; interrupt_signal SHALL clear in the same edge.
REQ-026 If interrupt_clear and a done pulse arrive in the same cycle, the set SHALL win.
REQ-027 busy SHALL be 1 in WAIT_LOAD, START and RUN, and 0 otherwise.
REQ-028 Arbitration: read_*_signal_data SHALL equal layer_read_*_signal[active_layer] only in RUN, else 0; read_*_addr_data SHALL equal the active slice in RUN, else 0; the path SHALL be combinational from registered state (zero latency).
REQ-029 Requests from non-active layers SHALL be ignored and never forwarded.
REQ-030 Any layer_calculation_done bit set for a non-active layer, or set outside RUN, SHALL set sticky seq_error; the FSM SHALL be unaffected.
REQ-031 seq_error SHALL clear only by reset or by interrupt_clear in IDLE/DONE.
REQ-032 pixel_store_done remaining high in DONE SHALL NOT restart the sequence until IDLE is re-entered.

Reset
REQ-033 On rst=1 the block SHALL asynchronously enter IDLE with active_layer=0, layer_start=0, busy=0, interrupt_signal=0, seq_error=0, all read outputs=0, and latched last_layer=0.
REQ-034 Reset mid-RUN SHALL abort the run; no start pulse or interrupt SHALL follow until the IDLE->WAIT_LOAD conditions recur.

Verification
REQ-035 Two-layer run, NUM_LAYERS=2, last_layer=1, all store_done=1, pixel_store_done pulse: start[0] at cycle 2, done[0] -> start[1] 2 cycles later, done[1] -> interrupt_signal=1 next cycle.
REQ-036 Stalled load: weight_store_done[1]=0 after layer 0 completes -> FSM holds WAIT_LOAD, busy=1, no start[1]; raise bit -> start[1] within 2 cycles.
REQ-037 Arbitration: in RUN with active_layer=1, layer 0 requests addr 0x0010 and layer 1 requests 0x0ABC -> read_weight_addr_data=0x0ABC and signal=1; in WAIT_LOAD both outputs are 0.
REQ-038 Early stop: NUM_LAYERS=4, last_layer=1 -> interrupt after layer 1, start[2] and start[3] never pulse; last_layer=7 clamps to 3.
REQ-039 Error and clear: done[1] pulse while active_layer=0 -> seq_error=1 and sequence continues; simultaneous interrupt_clear and final done -> interrupt_signal stays 1.
REQ-040 Reset mid-RUN: assert rst while busy=1 -> all outputs 0 immediately, no interrupt afterwards.
